pattern_serializer: RTL and testbench
=====================================

// Module: pattern_serializer
// PURPOSE
//   Upstream feeder for the serial 101 pattern detector. Accepts WIDTH-bit words over a
//   valid/ready handshake and shifts them out MSB-first, one bit per clock, on ser_out.
//   ser_out drives the detector's X input directly. A one-word hold buffer lets
//   back-to-back words stream with no idle gap.
// PARAMETERS
//   WIDTH       8   word width in bits, >= 2
//   IDLE_LEVEL  0   ser_out level while no word is being shifted
// PORTS
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   in_data     in   WIDTH  word to serialize
//   in_valid    in   1      in_data valid
//   in_ready    out  1      word accepted on an edge where in_valid && in_ready
//   ser_out     out  1      serial bit stream, registered (to detector X)
//   ser_valid   out  1      ser_out carries a frame bit this cycle
//   word_start  out  1      1-cycle pulse coincident with each word's MSB
//   busy        out  1      shifting, or hold buffer occupied
// BEHAVIOUR
//   Reset (async, immediate):
//     - state=IDLE; shift reg, hold buffer and bit counter cleared; hold empty
//     - ser_out=IDLE_LEVEL; ser_valid=0; word_start=0; busy=0; in_ready=1
//     - Reset mid-word discards the shift reg and hold contents; no partial-frame resume.
//   in_ready = !hold_full (combinational from register); no dependence on in_valid.
//   States: IDLE, SHIFT, PARITY (PARITY exists only with the macro).
//   IDLE:
//     - Accept at edge k: load shift reg; ser_out=in_data[WIDTH-1]; word_start=1;
//       ser_valid=1; go to SHIFT.
//     - Bits WIDTH-1..0 appear in cycles k+1..k+WIDTH.
//   SHIFT:
//     - Each edge advances one bit; bit counter counts WIDTH-1 down to 0.
//     - An accept during SHIFT writes the hold buffer.
//   Last-bit edge (counter==0), priority:
//     1. hold full: load from hold, hold empties, MSB next cycle. No new accept
//        this edge, since in_ready=0.
//     2. hold empty and accept this edge: bypass straight into the shift reg.
//     3. Otherwise go to IDLE; ser_out=IDLE_LEVEL, ser_valid=0.
//   Word order is strictly preserved.
//   busy = (state!=IDLE) | hold_full.
// CONFIGURATION
//   Macro SER_PARITY_EN.
//   Defined:
//     - After bit 0, state PARITY emits even parity (^word) for 1 cycle: ser_valid=1,
//       word_start=0.
//     - Frame is WIDTH+1 cycles; the last-bit priority rules apply at the parity edge.
//   Undefined:
//     - No PARITY state; frame is WIDTH cycles; ports unchanged.
// STRUCTURE
//   Shared package pattern_pkg:
//     - state encodings ST_IDLE=2'b00, ST_SHIFT=2'b01, ST_PARITY=2'b10
//     - even-parity function
//   Bit counter width: $clog2(WIDTH).
//   Sub-module pattern_ser_hold: 1-entry hold register with full flag, write on accept,
//   read on last-bit edge. All other logic lives in pattern_serializer.
// TESTING  (WIDTH=8, IDLE_LEVEL=0, macro off unless stated)
//   1. 8'hA5 sent from IDLE at edge k:
//      - ser_out = 1,0,1,0,0,1,0,1 in cycles k+1..k+8; ser_valid high for exactly 8 cycles
//      - word_start high only in k+1; then idle 0 and busy=0
//   2. 8'hF0 then 8'h0F, in_valid held high:
//      - 16 contiguous ser_valid cycles, no gap; in_ready low while hold full
//      - word_start at cycles 1 and 9
//   3. Three words offered back to back:
//      - third stalls (in_ready=0) until the first word's last-bit edge
//      - all 24 bits emitted in order
//   4. rst_n low at bit 4 of 8'hFF with a word in hold:
//      - outputs return to reset values immediately; after release, no stale bits
//        and in_ready=1
//   5. SER_PARITY_EN, 8'h07 then 8'h03:
//      - frames 0000_0111+1 and 0000_0011+0, 18 contiguous valid cycles
//   6. Stream 8'hAA into pattern_serializer -> 101 detector:
//      - Y asserts on each completed 1-0-1 in the stream, no match across idle zeros

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared types and helpers for the pattern serializer / 101 detector slice.
// Used by pattern_serializer; the SER_PARITY_EN build adds the parity state.
package pattern_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SHIFT  = 2'b01,
    ST_PARITY = 2'b10
  } state_t;

  localparam int unsigned PARITY_MAX_W = 64;

  // Zero-extension does not change the XOR, so callers pass any word up to 64 bits.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/pattern_ser_hold.sv
// One-entry hold register with full flag: written on an accept during a frame,
// read (emptied) when the serializer reloads on its last-bit edge.
module pattern_ser_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd,
  output logic [WIDTH-1:0] data,
  output logic             full
);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  // NOTE: the data word is reset as well, so a reset mid-frame leaves no stale word behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      full <= 1'b0;
    end else begin
      if (wr) data <= wr_data;
      if (wr)      full <= 1'b1;
      else if (rd) full <= 1'b0;
    end
  end

endmodule

// File: rtl/pattern_serializer.sv
// MSB-first word serializer feeding the 101 detector's X input, with a one-word
// hold buffer for gapless streaming. Define SER_PARITY_EN to append an even-parity bit.
module pattern_serializer
  import pattern_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_start,
  output logic             busy
);

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state, state_next;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ser_out_d, ser_valid_d, word_start_d;

  logic               hold_full, hold_wr, hold_rd;
  logic [WIDTH-1:0]   hold_data;

  logic               accept, frame_end, load_hold, load_bypass, do_load;
  logic [WIDTH-1:0]   load_word;

`ifdef SER_PARITY_EN
  logic               parity_q, parity_d;
`endif

  assign in_ready = !hold_full;
  assign busy     = (state != ST_IDLE) | hold_full;
  assign accept   = in_valid && in_ready;

  // frame_end is the edge that closes the current frame (bit 0, or the parity bit).
`ifdef SER_PARITY_EN
  assign frame_end = (state == ST_PARITY);
`else
  assign frame_end = (state == ST_SHIFT) && (cnt_q == '0);
`endif

  // A queued word always wins over a fresh accept; in_ready is low then anyway.
  assign load_hold   = frame_end && hold_full;
  assign load_bypass = accept && ((state == ST_IDLE) || (frame_end && !hold_full));
  assign do_load     = load_hold || load_bypass;
  assign load_word   = load_hold ? hold_data : in_data;

  assign hold_wr = accept && !load_bypass;
  assign hold_rd = load_hold;

  pattern_ser_hold #(.WIDTH(WIDTH)) u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr      (hold_wr),
    .wr_data (in_data),
    .rd      (hold_rd),
    .data    (hold_data),
    .full    (hold_full)
  );

  always_comb begin
    // NOTE: every target gets a default first so no path leaves a latch behind.
    state_next   = state;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    ser_out_d    = ser_out;
    ser_valid_d  = ser_valid;
    word_start_d = 1'b0;
`ifdef SER_PARITY_EN
    parity_d     = parity_q;
`endif

    if (do_load) begin
      state_next   = ST_SHIFT;
      shift_d      = {load_word[WIDTH-2:0], 1'b0};
      cnt_d        = CNT_LAST;
      ser_out_d    = load_word[WIDTH-1];
      ser_valid_d  = 1'b1;
      word_start_d = 1'b1;
`ifdef SER_PARITY_EN
      parity_d     = even_parity(PARITY_MAX_W'(load_word));
`endif
    end else begin
      case (state)
        ST_SHIFT: begin
          if (cnt_q != '0) begin
            ser_out_d = shift_q[WIDTH-1];
            shift_d   = {shift_q[WIDTH-2:0], 1'b0};
            cnt_d     = cnt_q - 1'b1;
          end else begin
`ifdef SER_PARITY_EN
            state_next = ST_PARITY;
            ser_out_d  = parity_q;
`else
            state_next  = ST_IDLE;
            ser_out_d   = IDLE_LEVEL;
            ser_valid_d = 1'b0;
            shift_d     = '0;
`endif
          end
        end
        default: begin
          state_next  = ST_IDLE;
          ser_out_d   = IDLE_LEVEL;
          ser_valid_d = 1'b0;
          shift_d     = '0;
          cnt_d       = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      ser_out    <= IDLE_LEVEL;
      ser_valid  <= 1'b0;
      word_start <= 1'b0;
`ifdef SER_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      ser_out    <= ser_out_d;
      ser_valid  <= ser_valid_d;
      word_start <= word_start_d;
`ifdef SER_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_pattern_serializer.sv
// Scoreboard bench for pattern_serializer (WIDTH=8); SER_PARITY_EN adds the parity frame test.
module tb_pattern_serializer;

  localparam int   WIDTH      = 8;
  localparam logic IDLE_LEVEL = 1'b0;
`ifdef SER_PARITY_EN
  localparam int   FRAME      = WIDTH + 1;
`else
  localparam int   FRAME      = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready, ser_out, ser_valid, word_start, busy;

  typedef struct packed {
    logic bit_val;
    logic start;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_exp;
  int         errors = 0;
  int         checks = 0;
  int         cur_run = 0;
  int         max_run = 0;
  int         det_hits = 0;
  logic [2:0] det_hist = '0;

  pattern_serializer #(.WIDTH(WIDTH), .IDLE_LEVEL(IDLE_LEVEL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .word_start (word_start),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Output monitor: pops one expected bit per valid cycle, checks idle level otherwise,
  // and runs a reference 101 detector over the raw ser_out stream.
  always @(negedge clk) begin
    if (!rst_n) begin
      cur_run  = 0;
      det_hist = '0;
    end else begin
      det_hist = {det_hist[1:0], ser_out};
      if (det_hist == 3'b101) det_hits++;
      if (ser_valid === 1'b1) begin
        cur_run++;
        if (cur_run > max_run) max_run = cur_run;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_bit: ser_valid=1 ser_out=%0b with nothing pending", ser_out);
        end else begin
          mon_exp = sb.pop_front();
          if (ser_out !== mon_exp.bit_val || word_start !== mon_exp.start) begin
            errors++;
            $display("FAIL stream_bit: got ser_out=%0b word_start=%0b, expected %0b/%0b",
                     ser_out, word_start, mon_exp.bit_val, mon_exp.start);
          end
        end
      end else begin
        cur_run = 0;
        checks++;
        if (ser_out !== IDLE_LEVEL || word_start !== 1'b0 || ser_valid !== 1'b0) begin
          errors++;
          $display("FAIL idle_level: got ser_out=%0b word_start=%0b ser_valid=%0b, expected %0b/0/0",
                   ser_out, word_start, ser_valid, IDLE_LEVEL);
        end
      end
    end
  end

  task automatic push_word(input logic [WIDTH-1:0] d);
    for (int i = WIDTH - 1; i >= 0; i--) sb.push_back('{bit_val: d[i], start: (i == WIDTH - 1)});
`ifdef SER_PARITY_EN
    sb.push_back('{bit_val: ^d, start: 1'b0});
`endif
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge, in_valid left high.
  task automatic offer(input logic [WIDTH-1:0] d, output int waited);
    in_data  = d;
    in_valid = 1'b1;
    waited   = 0;
    while (in_ready !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout: word %h not accepted after %0d cycles", d, waited);
      in_valid = 1'b0;
    end else begin
      push_word(d);
      @(negedge clk);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: %0d bits still pending, busy=%0b, expected 0/0", name, sb.size(), busy);
    end
    @(negedge clk);
  endtask

  task automatic check_run(input string name, input int expected);
    checks++;
    if (max_run !== expected) begin
      errors++;
      $display("FAIL %s_run: contiguous valid cycles=%0d, expected %0d", name, max_run, expected);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (ser_out !== IDLE_LEVEL || ser_valid !== 1'b0 || word_start !== 1'b0 ||
        busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: ser_out=%0b ser_valid=%0b word_start=%0b busy=%0b in_ready=%0b, expected %0b/0/0/0/1",
               name, ser_out, ser_valid, word_start, busy, in_ready, IDLE_LEVEL);
    end
  endtask

  task automatic test_reset();
    #2;
    check_reset_outputs("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int w;
    max_run = 0;
    offer(8'hA5, w);
    in_valid = 1'b0;
    wait_drain("single");
    check_run("single", FRAME);
  endtask

  task automatic test_back_to_back();
    int w;
    max_run = 0;
    offer(8'hF0, w);
    offer(8'h0F, w);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL hold_full_ready: in_ready=%0b busy=%0b, expected 0/1", in_ready, busy);
    end
    wait_drain("back_to_back");
    check_run("back_to_back", 2 * FRAME);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_drain: in_ready=%0b, expected 1", in_ready);
    end
  endtask

  task automatic test_stall();
    int w;
    max_run = 0;
    offer(8'h3C, w);
    offer(8'hC3, w);
    offer(8'h99, w);
    in_valid = 1'b0;
    checks++;
    if (w !== FRAME - 1) begin
      errors++;
      $display("FAIL third_stall: third word waited %0d cycles, expected %0d", w, FRAME - 1);
    end
    wait_drain("stall");
    check_run("stall", 3 * FRAME);
  endtask

  task automatic test_reset_mid_word();
    int w;
    offer(8'hFF, w);
    offer(8'h5A, w);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check_reset_outputs("reset_mid_word");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (FRAME * 2 + 2) @(negedge clk);
    check_reset_outputs("after_reset_release");
  endtask

`ifdef SER_PARITY_EN
  task automatic test_parity();
    int w;
    max_run = 0;
    offer(8'h07, w);
    offer(8'h03, w);
    in_valid = 1'b0;
    wait_drain("parity");
    check_run("parity", 2 * (WIDTH + 1));
  endtask
`endif

  task automatic test_detector();
    int w;
    det_hits = 0;
    offer(8'hAA, w);
    in_valid = 1'b0;
    wait_drain("detector_a");
    repeat (4) @(negedge clk);
    offer(8'hAA, w);
    in_valid = 1'b0;
    wait_drain("detector_b");
    repeat (3) @(negedge clk);
    checks++;
    if (det_hits !== 6) begin
      errors++;
      $display("FAIL detector_hits: 101 matches=%0d, expected 6", det_hits);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid_word();
`ifdef SER_PARITY_EN
    test_parity();
`endif
    test_detector();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
